// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory: streams a big-endian program in through a ready/valid
// byte port, then serves one 32-bit word per cycle. Optional macro IMEM_FAULT_EN adds alignment faults.
module inst_mem_loadable #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_last,
    output logic        load_ready,
    output logic        running,
    input  logic [31:0] address,
    input  logic        freeze,
    input  logic        flush,
    output logic [31:0] Inst,
    output logic        inst_valid,
    output logic        addr_fault
);

    typedef enum logic {S_LOAD, S_RUN} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH_WORDS);

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] asm_q, asm_d;
    logic        accept;
    logic        commit;
    logic [31:0] commit_word;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   inst_q;
    logic          valid_q;
    logic          fault_q;
    logic [AW-1:0] fetch_idx;
    logic          high_zero;
    logic          in_range;
    logic          fetch_legal;
    logic          fetch_fault;

    assign load_ready = (state_q == S_LOAD) && !rst && (wr_ptr_q < DEPTH_L);
    assign running    = (state_q == S_RUN);
    assign accept     = load_valid && load_ready;
    assign commit     = accept && ((byte_cnt_q == 2'd3) || load_last);

    // asm_q holds the first three bytes; bytes not yet received stay zero so a
    // load_last commit pads the low-order bytes with 0.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        commit_word = 32'h0;
        case (byte_cnt_q)
            2'd0:    commit_word = {load_byte, 24'h0};
            2'd1:    commit_word = {asm_q[23:16], load_byte, 16'h0};
            2'd2:    commit_word = {asm_q[23:8], load_byte, 8'h0};
            default: commit_word = {asm_q, load_byte};
        endcase
        if (accept) begin
            case (byte_cnt_q)
                2'd0:    asm_d = {load_byte, 16'h0};
                2'd1:    asm_d[15:8] = load_byte;
                2'd2:    asm_d[7:0] = load_byte;
                default: asm_d = asm_q;
            endcase
            if (commit) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                byte_cnt_d = 2'd0;
                if (load_last || (wr_ptr_d == DEPTH_L)) begin
                    state_d = S_RUN;
                end
            end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            wr_ptr_q   <= '0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'h0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
        end
    end

    // Contents survive reset; wr_ptr bounds what can be read back.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr_q[AW-1:0]] <= commit_word;
        end
    end

    assign fetch_idx = address[AW+1:2];
    assign high_zero = ((address >> (AW + 2)) == 32'd0);
    assign in_range  = high_zero && ({1'b0, fetch_idx} < wr_ptr_q);

`ifdef IMEM_FAULT_EN
    assign fetch_legal = in_range && (address[1:0] == 2'b00);
    assign fetch_fault = !fetch_legal;
`else
    // Byte offset is deliberately ignored: misaligned addresses truncate to the word.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^address[1:0];
    assign fetch_legal      = in_range;
    assign fetch_fault      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || (state_q == S_LOAD) || flush) begin
            inst_q  <= 32'h0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (!freeze) begin
            valid_q <= 1'b1;
            if (fetch_legal) begin
                inst_q  <= mem[fetch_idx];
                fault_q <= 1'b0;
            end else begin
                inst_q  <= 32'h0;
                fault_q <= fetch_fault;
            end
        end
    end

    assign Inst       = inst_q;
    assign inst_valid = valid_q;
    assign addr_fault = fault_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Directed bench for inst_mem_loadable (DEPTH_WORDS = 4); expectations queued per fetch
// and checked one cycle later. Fault-dependent expectations follow IMEM_FAULT_EN.
module tb_inst_mem_loadable;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    logic        running;
    logic [31:0] address;
    logic        freeze;
    logic        flush;
    logic [31:0] Inst;
    logic        inst_valid;
    logic        addr_fault;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef IMEM_FAULT_EN
    localparam logic FE = 1'b1;
`else
    localparam logic FE = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] inst;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t sb[$];

    inst_mem_loadable #(.DEPTH_WORDS(4), .AW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .load_ready (load_ready),
        .running    (running),
        .address    (address),
        .freeze     (freeze),
        .flush      (flush),
        .Inst       (Inst),
        .inst_valid (inst_valid),
        .addr_fault (addr_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        load_valid = 1'b1;
        tick();
        chk("rst_load_ready", {31'h0, load_ready}, 32'h0);
        tick();
        rst        = 1'b0;
        load_valid = 1'b0;
        chk("rst_running", {31'h0, running}, 32'h0);
        chk("rst_inst", Inst, 32'h0);
        chk("rst_valid_fault", {30'h0, inst_valid, addr_fault}, 32'h0);
        #1;
        chk("post_rst_ready", {31'h0, load_ready}, 32'h1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        #1;
        chk($sformatf("ready_before_%h", b), {31'h0, load_ready}, 32'h1);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        $display("load byte %h last=%0b running=%0b", b, last, running);
    endtask

    task automatic fetch(input string tag, input logic [31:0] a, input logic frz, input logic fl,
                         input logic [31:0] e_inst, input logic e_valid, input logic e_fault);
        exp_t e;
        exp_t got;
        address = a;
        freeze  = frz;
        flush   = fl;
        e.tag = tag; e.inst = e_inst; e.valid = e_valid; e.fault = e_fault;
        sb.push_back(e);
        tick();
        freeze = 1'b0;
        flush  = 1'b0;
        got = sb.pop_front();
        $display("fetch %s addr=%h frz=%0b fl=%0b -> Inst=%h v=%0b f=%0b", got.tag, a, frz, fl,
                 Inst, inst_valid, addr_fault);
        chk({got.tag, "_inst"}, Inst, got.inst);
        chk({got.tag, "_valid"}, {31'h0, inst_valid}, {31'h0, got.valid});
        chk({got.tag, "_fault"}, {31'h0, addr_fault}, {31'h0, got.fault});
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_byte = 8'h0; load_last = 1'b0;
        address = 32'h0; freeze = 1'b0; flush = 1'b0;
        do_reset();

        // Two-word program, with an idle gap mid-word.
        send_byte(8'hE3, 1'b0);
        send_byte(8'hA0, 1'b0);
        tick();
        chk("load_inst_zero", Inst, 32'h0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'hE3, 1'b0);
        send_byte(8'hA0, 1'b0);
        send_byte(8'h1A, 1'b0);
        chk("not_running_yet", {31'h0, running}, 32'h0);
        send_byte(8'h01, 1'b1);
        chk("running_after_last", {31'h0, running}, 32'h1);
        chk("ready_low_run", {31'h0, load_ready}, 32'h0);
        fetch("f0", 32'h0, 1'b0, 1'b0, 32'hE3A00014, 1'b1, 1'b0);
        fetch("f4", 32'h4, 1'b0, 1'b0, 32'hE3A01A01, 1'b1, 1'b0);
        fetch("f8_unloaded", 32'h8, 1'b0, 1'b0, 32'h0, 1'b1, FE);
        fetch("f2_misalign", 32'h2, 1'b0, 1'b0, FE ? 32'h0 : 32'hE3A00014, 1'b1, FE);
        fetch("f_high", 32'h1000_0000, 1'b0, 1'b0, 32'h0, 1'b1, FE);
        fetch("f0_again", 32'h0, 1'b0, 1'b0, 32'hE3A00014, 1'b1, 1'b0);
        fetch("frz1", 32'h4, 1'b1, 1'b0, 32'hE3A00014, 1'b1, 1'b0);
        fetch("frz2", 32'h4, 1'b1, 1'b0, 32'hE3A00014, 1'b1, 1'b0);
        fetch("frz_flush", 32'h4, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        fetch("frz_after_flush", 32'h4, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        fetch("f4_resume", 32'h4, 1'b0, 1'b0, 32'hE3A01A01, 1'b1, 1'b0);
        fetch("flush_only", 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

        // Partial final word padded with zeros.
        do_reset();
        send_byte(8'hE1, 1'b0);
        send_byte(8'hA0, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("partial_not_running", {31'h0, running}, 32'h0);
        send_byte(8'hE5, 1'b1);
        chk("partial_running", {31'h0, running}, 32'h1);
        fetch("p4", 32'h4, 1'b0, 1'b0, 32'hE500_0000, 1'b1, 1'b0);
        fetch("p0", 32'h0, 1'b0, 1'b0, 32'hE1A0_0000, 1'b1, 1'b0);

        // Fill all four words without load_last.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h10 + i), 1'b0);
        end
        chk("full_ready_low", {31'h0, load_ready}, 32'h0);
        chk("full_running", {31'h0, running}, 32'h1);
        fetch("full16", 32'h10, 1'b0, 1'b0, 32'h0, 1'b1, FE);
        fetch("full12", 32'hC, 1'b0, 1'b0, 32'h1C1D1E1F, 1'b1, 1'b0);
        fetch("full0", 32'h0, 1'b0, 1'b0, 32'h10111213, 1'b1, 1'b0);

        // Reset mid-load of the second word, then reload a single word.
        do_reset();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        do_reset();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b1);
        fetch("reload0", 32'h0, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b0);
        fetch("reload4", 32'h4, 1'b0, 1'b0, 32'h0, 1'b1, FE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
